// File: rtl/sgf_left_normalizer.sv
// Iterative left-shift normalizer: strips leading zeros one bit per cycle.
// Optional exponent adjust when NORM_EXP_ADJ_EN is defined.
module sgf_left_normalizer #(
    parameter int W_Sgf = 23,
    parameter int W_Cnt = 5
`ifdef NORM_EXP_ADJ_EN
    ,
    parameter int W_Exp = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_Sgf:0]   Sgf_In,
`ifdef NORM_EXP_ADJ_EN
    input  logic [W_Exp-1:0] Exp_In,
`endif
    output logic             busy,
    output logic             done,
    output logic [W_Sgf:0]   Sgf_Norm,
    output logic [W_Cnt-1:0] Shift_Count,
`ifdef NORM_EXP_ADJ_EN
    output logic             zero_flag,
    output logic [W_Exp-1:0] Exp_Out,
    output logic             exp_uf
`else
    output logic             zero_flag
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [W_Sgf:0]   r_work;
    logic [W_Cnt-1:0] r_cnt;
    logic [W_Sgf:0]   r_norm;
    logic [W_Cnt-1:0] r_count;
    logic             r_zf;
    logic             w_in_zero;
    logic             w_accept;

    assign w_in_zero = (Sgf_In == '0);
    assign w_accept  = start && (r_state != S_SHIFT);

`ifdef NORM_EXP_ADJ_EN
    localparam int W_M = (W_Cnt > W_Exp) ? W_Cnt : W_Exp;

    logic [W_Exp-1:0] r_exp;
    logic [W_Exp-1:0] r_exp_out;
    logic             r_uf;
    logic [W_Exp-1:0] w_exp_sub;
    logic             w_uf;

    assign w_exp_sub = r_exp - W_Exp'(r_cnt);
    assign w_uf      = W_M'(r_cnt) > W_M'(r_exp);

    // Exponent capture at start and adjusted result when the shift finishes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp     <= '0;
            r_exp_out <= '0;
            r_uf      <= 1'b0;
        end else if (w_accept) begin
            r_exp <= Exp_In;
            if (w_in_zero) begin
                r_exp_out <= '0;
                r_uf      <= 1'b0;
            end
        end else if (r_state == S_SHIFT && r_work[W_Sgf]) begin
            r_exp_out <= w_exp_sub;
            r_uf      <= w_uf;
        end
    end

    assign Exp_Out = r_exp_out;
    assign exp_uf  = r_uf;
`endif

    // Control FSM, working shifter and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_norm  <= '0;
            r_count <= '0;
            r_zf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_work <= Sgf_In;
                        r_cnt  <= '0;
                        r_zf   <= w_in_zero;
                        if (w_in_zero) begin
                            r_state <= S_DONE;
                            r_norm  <= '0;
                            r_count <= '0;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_work[W_Sgf]) begin
                        r_state <= S_DONE;
                        r_norm  <= r_work;
                        r_count <= r_cnt;
                    end else begin
                        r_work <= r_work << 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_SHIFT);
    assign done        = (r_state == S_DONE);
    assign Sgf_Norm    = r_norm;
    assign Shift_Count = r_count;
    assign zero_flag   = r_zf;

endmodule

// File: tb/tb_sgf_left_normalizer.sv
// Directed table-driven bench for sgf_left_normalizer (single precision).
// Exponent checks are compiled in when NORM_EXP_ADJ_EN is defined.
module tb_sgf_left_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] Sgf_In;
    logic        busy;
    logic        done;
    logic [23:0] Sgf_Norm;
    logic [4:0]  Shift_Count;
    logic        zero_flag;
`ifdef NORM_EXP_ADJ_EN
    logic [7:0]  Exp_In;
    logic [7:0]  Exp_Out;
    logic        exp_uf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sgf_left_normalizer #(.W_Sgf(23), .W_Cnt(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Sgf_In     (Sgf_In),
`ifdef NORM_EXP_ADJ_EN
        .Exp_In     (Exp_In),
        .Exp_Out    (Exp_Out),
        .exp_uf     (exp_uf),
`endif
        .busy       (busy),
        .done       (done),
        .Sgf_Norm   (Sgf_Norm),
        .Shift_Count(Shift_Count),
        .zero_flag  (zero_flag)
    );

    typedef struct {
        logic [23:0] sgf;
        logic [7:0]  ein;
        int          lat;
        logic [23:0] norm;
        logic [4:0]  cnt;
        logic        zf;
        logic [7:0]  eout;
        logic        uf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [23:0] s, input logic [7:0] e);
        @(negedge clk);
        Sgf_In = s;
`ifdef NORM_EXP_ADJ_EN
        Exp_In = e;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        Sgf_In = 24'hFFFFFF;
`ifdef NORM_EXP_ADJ_EN
        Exp_In = 8'h55;
`endif
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    task automatic chk_res(input string tag, input logic [23:0] norm,
                           input logic [4:0] cnt, input logic zf,
                           input logic [7:0] eout, input logic uf);
        chk({tag, "_norm"}, 32'(Sgf_Norm), 32'(norm));
        chk({tag, "_cnt"}, 32'(Shift_Count), 32'(cnt));
        chk({tag, "_zf"}, 32'(zero_flag), 32'(zf));
`ifdef NORM_EXP_ADJ_EN
        chk({tag, "_eout"}, 32'(Exp_Out), 32'(eout));
        chk({tag, "_uf"}, 32'(exp_uf), 32'(uf));
`else
        if (eout === 8'hxx && uf === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tot;
        int pulses;

        vecs[0] = '{24'h800000, 8'd5,   1,  24'h800000, 5'd0,  1'b0, 8'd5,   1'b0};
        vecs[1] = '{24'h000001, 8'd30,  24, 24'h800000, 5'd23, 1'b0, 8'd7,   1'b0};
        vecs[2] = '{24'h000000, 8'd77,  0,  24'h000000, 5'd0,  1'b1, 8'd0,   1'b0};
        vecs[3] = '{24'h0C0000, 8'd4,   5,  24'hC00000, 5'd4,  1'b0, 8'd0,   1'b0};
        vecs[4] = '{24'h400001, 8'd0,   2,  24'h800002, 5'd1,  1'b0, 8'hFF,  1'b1};
        vecs[5] = '{24'h00ABCD, 8'd200, 9,  24'hABCD00, 5'd8,  1'b0, 8'd192, 1'b0};
        vecs[6] = '{24'h7FFFFF, 8'd1,   2,  24'hFFFFFE, 5'd1,  1'b0, 8'd0,   1'b0};
        vecs[7] = '{24'h000100, 8'd20,  16, 24'h800000, 5'd15, 1'b0, 8'd5,   1'b0};
        vecs[8] = '{24'h010000, 8'd3,   8,  24'h800000, 5'd7,  1'b0, 8'hFC,  1'b1};
        vecs[9] = '{24'h010000, 8'd10,  8,  24'h800000, 5'd7,  1'b0, 8'd3,   1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        Sgf_In = '0;
`ifdef NORM_EXP_ADJ_EN
        Exp_In = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_res("rst", 24'h0, 5'd0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            start_job(vecs[i].sgf, vecs[i].ein);
            chk({tag, "_busy"}, 32'(busy), 32'(!vecs[i].zf));
            wait_done(n);
            chk({tag, "_lat"}, 32'(n), 32'(vecs[i].lat));
            chk_res(tag, vecs[i].norm, vecs[i].cnt, vecs[i].zf,
                    vecs[i].eout, vecs[i].uf);
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, 32'(Sgf_Norm), 32'(vecs[i].norm));
        end

        // start re-pulsed while busy must be ignored
        start_job(24'h0C0000, 8'd9);
        @(posedge clk);
        #1;
        Sgf_In = 24'h000001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ign_lat", 32'(n + 2), 32'd5);
        chk_res("ign", 24'hC00000, 5'd4, 1'b0, 8'd5, 1'b0);

        // back-to-back: starts accepted straight out of DONE
        start_job(24'h800000, 8'd9);
        wait_done(n);
        chk("b2b0_lat", 32'(n), 32'd1);
        Sgf_In = 24'h000000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b1_done", 32'(done), 32'd1);
        chk_res("b2b1", 24'h0, 5'd0, 1'b1, 8'd0, 1'b0);
        Sgf_In = 24'h000003;
`ifdef NORM_EXP_ADJ_EN
        Exp_In = 8'd30;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b2_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b2_lat", 32'(n), 32'd23);
        chk_res("b2b2", 24'hC00000, 5'd22, 1'b0, 8'd8, 1'b0);

        // reset in the middle of a shift job
        start_job(24'h000010, 8'd50);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk_res("mrst", 24'h0, 5'd0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        tot = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            tot++;
        end
        chk("mrst_nopulse", 32'(pulses), 32'd0);
        chk("mrst_cnt", 32'(Shift_Count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
